// File: rtl/caliptra_ext_mem_loader_pkg.sv
// Shared state encoding, channel indices and default per-channel depths
// for the multi-channel backdoor SRAM loader.
package caliptra_ext_mem_loader_pkg;

    typedef enum logic [1:0] {
        LDR_IDLE  = 2'd0,
        LDR_WR    = 2'd1,
        LDR_RD    = 2'd2,
        LDR_DRAIN = 2'd3
    } ldr_state_e;

    localparam int LDR_NUM_MEM_DFLT = 3;
    localparam int LDR_MEM_DEPTH_DFLT [LDR_NUM_MEM_DFLT] = '{8192, 32768, 16384};

    localparam int LDR_IMEM = 0;
    localparam int LDR_MBOX = 1;
    localparam int LDR_ICCM = 2;

endpackage

// File: rtl/caliptra_ext_mem_loader_rdfifo.sv
// Two-entry read-return FIFO; tracks the single in-flight SRAM read so that
// buffered plus outstanding words never exceed the two storage slots.
module caliptra_ext_mem_loader_rdfifo #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_issue,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic              i_pop,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_data,
    output logic              o_credit,
    output logic              o_idle
);

    logic              r_inflight_p1;
    logic [1:0]        r_count;
    logic              r_wptr;
    logic              r_rptr;
    logic [DATA_W-1:0] r_mem [2];

    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_occ;

    assign w_push = r_inflight_p1 && !i_flush;
    assign w_pop  = i_pop && (r_count != 2'd0) && !i_flush;
    assign w_occ  = r_count + {1'b0, r_inflight_p1};

    // A pop this cycle frees a slot in time for a word issued now, keeping 1 word/cycle.
    assign o_credit = (w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop);
    assign o_vld    = (r_count != 2'd0);
    assign o_data   = r_mem[r_rptr];
    assign o_idle   = (r_count == 2'd0) && !r_inflight_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight_p1 <= 1'b0;
            r_count       <= 2'd0;
            r_wptr        <= 1'b0;
            r_rptr        <= 1'b0;
        end else if (i_flush) begin
            r_inflight_p1 <= 1'b0;
            r_count       <= 2'd0;
            r_wptr        <= 1'b0;
            r_rptr        <= 1'b0;
        end else begin
            r_inflight_p1 <= i_issue;
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_rdata;
        end
    end

endmodule

// File: rtl/caliptra_ext_mem_loader.sv
// Backdoor burst loader/reader for NUM_MEM SRAM channels; the core always wins
// a channel it is using, and the loader stalls until the core lets go.
module caliptra_ext_mem_loader
    import caliptra_ext_mem_loader_pkg::*;
#(
    parameter int NUM_MEM = 3,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 15,
    parameter int LEN_W   = 16,
    parameter int MEM_DEPTH [NUM_MEM] = LDR_MEM_DEPTH_DFLT,
    localparam int SEL_W  = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1
) (
    input  logic                      clk,
    input  logic                      cptra_rst_b,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [SEL_W-1:0]          cmd_sel,
    input  logic                      cmd_write,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [LEN_W-1:0]          cmd_len,
    input  logic                      abort,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    input  logic [NUM_MEM-1:0]        core_cs,
    input  logic [NUM_MEM-1:0]        core_we,
    input  logic [NUM_MEM*ADDR_W-1:0] core_addr,
    input  logic [NUM_MEM*DATA_W-1:0] core_wdata,
    output logic [NUM_MEM*DATA_W-1:0] core_rdata,
    output logic [NUM_MEM-1:0]        mem_cs,
    output logic [NUM_MEM-1:0]        mem_we,
    output logic [NUM_MEM*ADDR_W-1:0] mem_addr,
    output logic [NUM_MEM*DATA_W-1:0] mem_wdata,
    input  logic [NUM_MEM*DATA_W-1:0] mem_rdata
);

    localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

    ldr_state_e        r_state;
    logic [SEL_W-1:0]  r_sel;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_rem;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_cmd_ready;

    logic [SUM_W-1:0]  w_end;
    logic [31:0]       w_depth;
    logic              w_sel_ok;
    logic              w_cmd_bad;
    logic              w_core_hit;
    logic [DATA_W-1:0] w_sel_rdata;
    logic              w_wr_fire;
    logic              w_rd_issue;
    logic              w_flush;
    logic              w_pop;
    logic              w_fifo_vld;
    logic              w_fifo_credit;
    logic              w_fifo_idle;

    always_comb begin
        w_depth     = '0;
        w_sel_ok    = 1'b0;
        w_core_hit  = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_MEM; i++) begin
            if (cmd_sel == SEL_W'(i)) begin
                w_depth  = 32'(MEM_DEPTH[i]);
                w_sel_ok = 1'b1;
            end
            if (r_sel == SEL_W'(i)) begin
                w_core_hit  = core_cs[i];
                w_sel_rdata = mem_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // End address is formed one bit wider than either operand so it cannot wrap.
    assign w_end     = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
    assign w_cmd_bad = (cmd_len == '0) || !w_sel_ok || (32'(w_end) > w_depth);

    assign wr_ready   = (r_state == LDR_WR) && !w_core_hit;
    assign w_wr_fire  = wr_ready && wr_valid;
    assign w_rd_issue = (r_state == LDR_RD) && !w_core_hit && (r_rem != '0)
                        && w_fifo_credit && !abort;
    assign w_flush    = abort && (r_state != LDR_IDLE);
    assign w_pop      = w_fifo_vld && rd_ready;

    assign rd_valid   = w_fifo_vld;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign cmd_ready  = r_cmd_ready;
    assign core_rdata = mem_rdata;

    always_comb begin
        for (int i = 0; i < NUM_MEM; i++) begin
            mem_cs[i]                      = core_cs[i];
            mem_we[i]                      = core_we[i];
            mem_addr[i*ADDR_W +: ADDR_W]   = core_addr[i*ADDR_W +: ADDR_W];
            mem_wdata[i*DATA_W +: DATA_W]  = core_wdata[i*DATA_W +: DATA_W];
            if ((w_wr_fire || w_rd_issue) && (r_sel == SEL_W'(i))) begin
                mem_cs[i]                     = 1'b1;
                mem_we[i]                     = w_wr_fire;
                mem_addr[i*ADDR_W +: ADDR_W]  = r_addr;
                mem_wdata[i*DATA_W +: DATA_W] = wr_data;
            end
        end
    end

    caliptra_ext_mem_loader_rdfifo #(
        .DATA_W (DATA_W)
    ) u_rdfifo (
        .clk      (clk),
        .rst_n    (cptra_rst_b),
        .i_flush  (w_flush),
        .i_issue  (w_rd_issue),
        .i_rdata  (w_sel_rdata),
        .i_pop    (w_pop),
        .o_vld    (w_fifo_vld),
        .o_data   (rd_data),
        .o_credit (w_fifo_credit),
        .o_idle   (w_fifo_idle)
    );

    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            r_state     <= LDR_IDLE;
            r_sel       <= '0;
            r_addr      <= '0;
            r_rem       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                LDR_IDLE: begin
                    if (cmd_valid) begin
                        if (w_cmd_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_sel       <= cmd_sel;
                            r_addr      <= cmd_addr;
                            r_rem       <= cmd_len;
                            r_state     <= cmd_write ? LDR_WR : LDR_RD;
                            r_busy      <= 1'b1;
                            r_cmd_ready <= 1'b0;
                        end
                    end
                end
                LDR_WR: begin
                    if (w_wr_fire) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        r_rem  <= r_rem - LEN_W'(1);
                    end
                    if (abort) begin
                        r_state     <= LDR_IDLE;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end else if (w_wr_fire && (r_rem == LEN_W'(1))) begin
                        r_state     <= LDR_IDLE;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_done      <= 1'b1;
                    end
                end
                LDR_RD: begin
                    if (w_rd_issue) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        r_rem  <= r_rem - LEN_W'(1);
                        if (r_rem == LEN_W'(1)) begin
                            r_state <= LDR_DRAIN;
                        end
                    end
                    if (abort) begin
                        r_state     <= LDR_IDLE;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                LDR_DRAIN: begin
                    if (abort) begin
                        r_state     <= LDR_IDLE;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end else if (w_fifo_idle) begin
                        r_state     <= LDR_IDLE;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_done      <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= LDR_IDLE;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/caliptra_ext_mem_loader.md
Name: caliptra_ext_mem_loader

Overview:
- Multi-channel backdoor loader/reader for the verilated model. It generalises the single-memory external imem write port into NUM_MEM SRAM channels (imem, mailbox, ICCM/DCCM preload).
- Supports burst writes and read-back from the C++ harness, with auto-incrementing address, bounds checking and core-priority arbitration.
- Sits between caliptra_top SRAM ports and caliptra_sram instances, inside the verilated wrapper.

Parameters:
- NUM_MEM, 3, number of SRAM channels.
- DATA_W, 64, SRAM word width; narrower memories use the low bits.
- ADDR_W, 15, word-address width for all channels.
- LEN_W, 16, burst length field width.
- MEM_DEPTH, '{8192,32768,16384}, per-channel depth in words; array of NUM_MEM ints.

Ports:
- clk  in  1  core clock
- cptra_rst_b  in  1  async active-low reset
- cmd_valid  in  1  command offer
- cmd_ready  out  1  command accepted when valid&ready
- cmd_sel  in  SEL_W=$clog2(NUM_MEM)  target channel
- cmd_write  in  1  1=burst write, 0=burst read
- cmd_addr  in  ADDR_W  start word address
- cmd_len  in  LEN_W  word count; 0 is illegal
- abort  in  1  cancel active burst
- wr_valid / wr_ready  in / out  1  write-data handshake
- wr_data  in  DATA_W  write word
- rd_valid / rd_ready  out / in  1  read-data handshake
- rd_data  out  DATA_W  read word
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse, burst complete
- err  out  1  one-cycle pulse, command rejected
- core_cs, core_we  in  NUM_MEM  core-side requests
- core_addr  in  NUM_MEM x ADDR_W
- core_wdata  in  NUM_MEM x DATA_W
- core_rdata  out  NUM_MEM x DATA_W  passthrough of mem_rdata
- mem_cs, mem_we  out  NUM_MEM  SRAM controls
- mem_addr  out  NUM_MEM x ADDR_W
- mem_wdata  out  NUM_MEM x DATA_W
- mem_rdata  in  NUM_MEM x DATA_W  1-cycle read latency

Behaviour:
- Reset values:
  - FSM=IDLE; busy, done, err, rd_valid = 0.
  - cmd_ready=1 in IDLE.
  - Read buffer empty, address/count registers 0.
- FSM states: IDLE, WR, RD, DRAIN.
- IDLE command acceptance on cmd_valid:
  - Reject if cmd_len==0, cmd_sel>=NUM_MEM, or cmd_addr+cmd_len>MEM_DEPTH[cmd_sel] (compute in ADDR_W+1 / LEN_W+1 bits, no wrap).
  - Reject: pulse err the next cycle, stay IDLE.
  - Accept: latch sel/addr/len, go to WR or RD next cycle; busy=1.
- cmd_ready=0 in every non-IDLE state.
- Arbitration, per channel each cycle:
  - Channel sel's core_cs=1: core owns the SRAM and the loader stalls (wr_ready=0, no read issue).
  - Core signals pass straight to mem_* on non-selected channels and in IDLE.
- WR state:
  - wr_ready = !core_cs[sel].
  - On wr_valid&wr_ready: mem_cs/mem_we=1, mem_wdata=wr_data, address increments, remaining count decrements.
  - After the last beat, go to IDLE and pulse done the next cycle.
- RD state:
  - Issue a read when !core_cs[sel], remaining>0, and (buffered + in-flight) < 2.
  - mem_rdata[sel] is captured into a 2-entry FIFO one cycle after issue.
  - rd_valid = FIFO non-empty; pop on rd_ready.
  - When the last read is issued, go to DRAIN.
- DRAIN: when the FIFO is empty and nothing is in flight, go to IDLE and pulse done.
- Throughput: 1 word/cycle sustained with no core contention and rd_ready held high. First rd_valid appears 2 cycles after entering RD.
- Abort:
  - In any busy state, next cycle goes to IDLE; FIFO and in-flight read are discarded.
  - No done, no err.
  - SRAM write accepted in the same cycle as abort is still performed.
- cmd_valid while busy is ignored, with no err.
- Core and loader never drive mem_cs on the same channel in the same cycle.
- Reset mid-burst: asynchronous return to reset values; partially written data remains in the SRAM.
- core_rdata[i] = mem_rdata[i] always. The core ignores data for cycles it did not request.

Decomposition:
- Shared package caliptra_ext_mem_loader_pkg:
  - ldr_state_e enum.
  - Default MEM_DEPTH array.
  - Channel index constants LDR_IMEM=0, LDR_MBOX=1, LDR_ICCM=2.
- Sub-module caliptra_ext_mem_loader_rdfifo: 2-entry FIFO with in-flight credit counter, parametrised by DATA_W.

Test Plan:
- Write burst: sel=0, addr=0x10, len=4, data 0xA0..0xA3, no core traffic -> 4 consecutive mem writes at 0x10..0x13; done 1 cycle after last beat; read-back returns A0..A3.
- Contention: core_cs[0]=1 for cycles 2-3 of a 4-word write -> wr_ready low those 2 cycles; core access reaches SRAM unmodified; done 2 cycles later than uncontended.
- Bounds: sel=1, addr=32766, len=3 (depth 32768) -> err pulse, no mem_cs; len=2 -> accepted. len=0 -> err.
- Read backpressure: sel=2, len=8, rd_ready toggling 1/0 -> no more than 2 words buffered, data in order, done only after the 8th pop.
- Abort mid-read: len=16, abort after 5 pops -> IDLE next cycle, rd_valid=0, no done/err; new command accepted immediately.
- Async reset asserted mid-write at word 3 of 6 -> busy/done/err/rd_valid=0 immediately; words 0-2 retained in SRAM.
